// File: rtl/apb_master_exe_seq.sv
// ---------------------------------------------------------------------------
// apb_master_exe_seq
//
// Runs one command as a fixed sequence of APB transfers. It writes the
// operation code and both operands to completer addresses 0..2. It then
// waits EXE_LAT idle cycles so the completer can execute. Finally it reads
// the result from address 0 and the status from address 1. A single-cycle
// response strobe reports the outcome.
//
// Handshake: a command transfers on the rising edge where i_req_valid and
// o_req_ready are both high. o_req_ready does not depend on i_req_valid.
// o_req_ready is high only while the sequencer is idle. o_rsp_valid is a
// one-cycle strobe with no back-pressure. The requester must take it when
// it is offered.
//
// Ports
//   i_PCLK, i_PRESETn             clock, asynchronous active-low reset
//   i_req_valid / o_req_ready     command handshake
//   i_oper, i_argA, i_argB        command operands (DATA_WIDTH each)
//   o_rsp_valid                   one-cycle response strobe
//   o_result, o_status, o_err     response fields; they hold until the
//                                 next response
//   o_PADDR .. o_PWDATA           APB requester outputs
//   i_PREADY, i_PRDATA, i_PSLVERR APB completer inputs
//   o_dbg_state                   current FSM state encoding
//
// TIMEOUT must be >= 1.
// ---------------------------------------------------------------------------
module apb_master_exe_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int EXE_LAT    = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_PCLK,
  input  logic                  i_PRESETn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [DATA_WIDTH-1:0] i_oper,
  input  logic [DATA_WIDTH-1:0] i_argA,
  input  logic [DATA_WIDTH-1:0] i_argB,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [3:0]            o_status,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_PADDR,
  output logic                  o_PSEL,
  output logic                  o_PENABLE,
  output logic                  o_PWRITE,
  output logic [DATA_WIDTH-1:0] o_PWDATA,
  input  logic                  i_PREADY,
  input  logic [DATA_WIDTH-1:0] i_PRDATA,
  input  logic                  i_PSLVERR,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_GAP    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ST_W0 = 3'd0,
    ST_W1 = 3'd1,
    ST_W2 = 3'd2,
    ST_R0 = 3'd3,
    ST_R1 = 3'd4
  } step_t;

  // The wait counter only has to reach TIMEOUT-1. The abort fires in the
  // ACCESS cycle that would be the TIMEOUT-th cycle with PREADY low.
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((EXE_LAT > 0) ? EXE_LAT - 1 : 0);

  state_t                state_q, state_d;
  step_t                 step_q, step_d;
  logic [WW-1:0]         wait_cnt_q;
  logic [GW-1:0]         gap_cnt_q;
  logic [DATA_WIDTH-1:0] oper_q, arga_q, argb_q, result_q;

  // Address, direction and write data of the transfer selected by the step.
  logic [ADDR_WIDTH-1:0] xfer_addr;
  logic                  xfer_write;
  logic [DATA_WIDTH-1:0] xfer_wdata;

  // Single-cycle events that load the response registers.
  logic done_ok, done_err;

  assign o_dbg_state = state_q;

  always_comb begin
    xfer_addr  = '0;
    xfer_write = 1'b0;
    xfer_wdata = '0;
    case (step_q)
      ST_W0: begin
        xfer_addr  = ADDR_WIDTH'(0);
        xfer_write = 1'b1;
        xfer_wdata = oper_q;
      end
      ST_W1: begin
        xfer_addr  = ADDR_WIDTH'(1);
        xfer_write = 1'b1;
        xfer_wdata = arga_q;
      end
      ST_W2: begin
        xfer_addr  = ADDR_WIDTH'(2);
        xfer_write = 1'b1;
        xfer_wdata = argb_q;
      end
      ST_R0: xfer_addr = ADDR_WIDTH'(0);
      ST_R1: xfer_addr = ADDR_WIDTH'(1);
      default: ;
    endcase
  end

  // Next state and outputs. The bus outputs are decoded from the state
  // register. An asynchronous reset therefore drops PSEL/PENABLE at once.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_PSEL      = 1'b0;
    o_PENABLE   = 1'b0;
    o_PWRITE    = 1'b0;
    o_PADDR     = '0;
    o_PWDATA    = '0;
    done_ok     = 1'b0;
    done_err    = 1'b0;
    case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          state_d = S_SETUP;
          step_d  = ST_W0;
        end
      end
      S_SETUP: begin
        o_PSEL   = 1'b1;
        o_PWRITE = xfer_write;
        o_PADDR  = xfer_addr;
        o_PWDATA = xfer_wdata;
        state_d  = S_ACCESS;
      end
      S_ACCESS: begin
        o_PSEL    = 1'b1;
        o_PENABLE = 1'b1;
        o_PWRITE  = xfer_write;
        o_PADDR   = xfer_addr;
        o_PWDATA  = xfer_wdata;
        if (i_PREADY) begin
          if (i_PSLVERR) begin
            state_d  = S_RESP;
            done_err = 1'b1;
          end else begin
            case (step_q)
              ST_W0: begin step_d = ST_W1; state_d = S_SETUP; end
              ST_W1: begin step_d = ST_W2; state_d = S_SETUP; end
              ST_W2: begin
                // The GAP state keeps ST_R0 as its step, so the read
                // starts straight from GAP.
                step_d  = ST_R0;
                state_d = (EXE_LAT > 0) ? S_GAP : S_SETUP;
              end
              ST_R0: begin step_d = ST_R1; state_d = S_SETUP; end
              ST_R1: begin state_d = S_RESP; done_ok = 1'b1; end
              default: begin state_d = S_RESP; done_err = 1'b1; end
            endcase
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d  = S_RESP;
          done_err = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_SETUP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
    if (!i_PRESETn) begin
      state_q    <= S_IDLE;
      step_q     <= ST_W0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      oper_q     <= '0;
      arga_q     <= '0;
      argb_q     <= '0;
      result_q   <= '0;
      o_result   <= '0;
      o_status   <= '0;
      o_err      <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;

      if (state_q == S_IDLE && i_req_valid) begin
        oper_q <= i_oper;
        arga_q <= i_argA;
        argb_q <= i_argB;
      end

      // Counts the cycles with PREADY low in the current transfer. The
      // counter wraps on abort, which is harmless because the next SETUP
      // clears it.
      if (state_q == S_SETUP) begin
        wait_cnt_q <= '0;
      end else if (state_q == S_ACCESS && !i_PREADY) begin
        wait_cnt_q <= wait_cnt_q + WW'(1);
      end

      if (state_q == S_GAP) begin
        gap_cnt_q <= gap_cnt_q + GW'(1);
      end else begin
        gap_cnt_q <= '0;
      end

      if (state_q == S_ACCESS && i_PREADY && !i_PSLVERR && step_q == ST_R0) begin
        result_q <= i_PRDATA;
      end

      // The status comes straight from the R1 read data. No register
      // holds it in between.
      if (done_ok) begin
        o_result <= result_q;
        o_status <= i_PRDATA[3:0];
        o_err    <= 1'b0;
      end else if (done_err) begin
        o_result <= '0;
        o_status <= '0;
        o_err    <= 1'b1;
      end
    end
  end

endmodule
